reg_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the RV32I integer core.
- Two combinational read ports (rs1/rs2 operands) and one synchronous write port (rd writeback).
- Register x0 is hardwired to zero.
- Sits between the decode stage (read addresses) and the writeback stage (write address/data/enable).

---
 rtl/reg_file.sv | 41 ++++
 tb/tb_reg_file.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32 x 32-bit RV32I integer register file: two combinational read ports and one write port.
// x0 has no storage and always reads as zero. Reset is synchronous and active-high.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_write,
  input  logic [DATA_WIDTH-1:0] data_write,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

  // Reset wins over a write in the same cycle; writes aimed at x0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_write && (addr_write != '0)) begin
      regs[addr_write] <= data_write;
    end
  end

  // No write-to-read bypass: a same-cycle write becomes visible only after the edge.
  always_comb begin
    data_a = '0;
    data_b = '0;
    if (addr_a != '0) data_a = regs[addr_a];
    if (addr_b != '0) data_b = regs[addr_b];
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking testbench for reg_file: reset, write/read, x0, enable gating,
// full sweep, and same-cycle write visibility followed by a mid-run reset.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [4:0]  addr_write;
  logic [31:0] data_write;
  logic [31:0] data_a;
  logic [31:0] data_b;

  int n_compared;
  int n_mismatched;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .addr_write (addr_write),
    .data_write (data_write),
    .data_a     (data_a),
    .data_b     (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge so the rising edge samples stable values.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    addr_write = a;
    data_write = d;
    @(negedge clk);
    reg_write  = 1'b0;
  endtask

  task automatic test_reset();
    addr_a = 5'd0;
    addr_b = 5'd0;
    #1;
    n_compared++;
    if (data_a !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL x0_before_reset: got %h expected %h", data_a, 32'd0);
    end
    @(negedge clk);
    reset      = 1'b1;
    reg_write  = 1'b1;
    addr_write = 5'd4;
    data_write = 32'd45;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    reg_write = 1'b0;
    addr_a    = 5'd4;
    addr_b    = 5'd31;
    #1;
    n_compared++;
    if (data_a !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_discards_write: got %h expected %h", data_a, 32'd0);
    end
    n_compared++;
    if (data_b !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_clear_x31: got %h expected %h", data_b, 32'd0);
    end
  endtask

  task automatic test_basic_write();
    write_reg(5'd4, 32'd45);
    write_reg(5'd5, 32'd64);
    addr_a = 5'd5;
    addr_b = 5'd4;
    #1;
    n_compared++;
    if (data_a !== 32'd64) begin
      n_mismatched++;
      $display("[TB] FAIL basic_x5: got %h expected %h", data_a, 32'd64);
    end
    n_compared++;
    if (data_b !== 32'd45) begin
      n_mismatched++;
      $display("[TB] FAIL basic_x4: got %h expected %h", data_b, 32'd45);
    end
  endtask

  task automatic test_x0();
    write_reg(5'd0, 32'd256);
    addr_a = 5'd0;
    addr_b = 5'd0;
    #1;
    n_compared++;
    if (data_a !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL x0_port_a: got %h expected %h", data_a, 32'd0);
    end
    n_compared++;
    if (data_b !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL x0_port_b: got %h expected %h", data_b, 32'd0);
    end
  endtask

  task automatic test_write_enable();
    @(negedge clk);
    reg_write  = 1'b0;
    addr_write = 5'd5;
    data_write = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    addr_a = 5'd5;
    addr_b = 5'd4;
    #1;
    n_compared++;
    if (data_a !== 32'd64) begin
      n_mismatched++;
      $display("[TB] FAIL we_gating_x5: got %h expected %h", data_a, 32'd64);
    end
    n_compared++;
    if (data_b !== 32'd45) begin
      n_mismatched++;
      $display("[TB] FAIL we_gating_x4: got %h expected %h", data_b, 32'd45);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i);
      addr_b = 5'(31 - i);
      exp_a  = 32'(i) * 32'h01010101;
      exp_b  = 32'(31 - i) * 32'h01010101;
      #1;
      n_compared++;
      if (data_a !== exp_a) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_a[%0d]: got %h expected %h", i, data_a, exp_a);
      end
      n_compared++;
      if (data_b !== exp_b) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_b[%0d]: got %h expected %h", 31 - i, data_b, exp_b);
      end
    end
    addr_a = 5'd7;
    addr_b = 5'd7;
    #1;
    n_compared++;
    if (data_a !== 32'h07070707) begin
      n_mismatched++;
      $display("[TB] FAIL same_addr_a: got %h expected %h", data_a, 32'h07070707);
    end
    n_compared++;
    if (data_b !== 32'h07070707) begin
      n_mismatched++;
      $display("[TB] FAIL same_addr_b: got %h expected %h", data_b, 32'h07070707);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    addr_a     = 5'd9;
    addr_b     = 5'd9;
    reg_write  = 1'b1;
    addr_write = 5'd9;
    data_write = 32'h12345678;
    #1;
    n_compared++;
    if (data_a !== 32'h09090909) begin
      n_mismatched++;
      $display("[TB] FAIL no_bypass_before_edge: got %h expected %h", data_a, 32'h09090909);
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (data_a !== 32'h12345678) begin
      n_mismatched++;
      $display("[TB] FAIL visible_after_edge: got %h expected %h", data_a, 32'h12345678);
    end
    @(negedge clk);
    reg_write = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i);
      addr_b = 5'(31 - i);
      #1;
      n_compared++;
      if (data_a !== 32'd0) begin
        n_mismatched++;
        $display("[TB] FAIL midrun_reset_a[%0d]: got %h expected %h", i, data_a, 32'd0);
      end
      n_compared++;
      if (data_b !== 32'd0) begin
        n_mismatched++;
        $display("[TB] FAIL midrun_reset_b[%0d]: got %h expected %h", 31 - i, data_b, 32'd0);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b0;
    reg_write    = 1'b0;
    addr_a       = 5'd0;
    addr_b       = 5'd0;
    addr_write   = 5'd0;
    data_write   = 32'd0;
    test_reset();
    test_basic_write();
    test_x0();
    test_write_enable();
    test_sweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
